dmem_arbiter: RTL

- Two-master arbiter for the single-port data memory.
- Requester 0 is the core load/store port; requester 1 is a secondary master (program loader/debug/DMA).
- Serialises accesses with round-robin fairness and one outstanding transaction at a time.
- Drives the data memory control, address and write-data nets; returns read data and a completion pulse to the granted requester.

---
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the single-port data memory.
// Latency: handshake in T, memory strobes T+1..T+MEM_LAT, Done in T+MEM_LAT+1.
// Backpressure: one access in flight; ReqX_Ready is only raised in IDLE, for the granted requester.
// Ports: Clk_Core/Rst_Core (sync, active-high); Req0_*/Req1_* valid/ready request
//        channels with Rdata + one-cycle Done; Mem_* drive the data memory; Busy = not idle.
module dmem_arbiter #(
    parameter int DWIDTH  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core,
    input  logic              Req0_Valid,
    output logic              Req0_Ready,
    input  logic [DWIDTH-1:0] Req0_Addr,
    input  logic [DWIDTH-1:0] Req0_Wdata,
    input  logic [3:0]        Req0_Wstrb,
    output logic [DWIDTH-1:0] Req0_Rdata,
    output logic              Req0_Done,
    input  logic              Req1_Valid,
    output logic              Req1_Ready,
    input  logic [DWIDTH-1:0] Req1_Addr,
    input  logic [DWIDTH-1:0] Req1_Wdata,
    input  logic [3:0]        Req1_Wstrb,
    output logic [DWIDTH-1:0] Req1_Rdata,
    output logic              Req1_Done,
    output logic [DWIDTH-1:0] Mem_Data_Addr,
    output logic [DWIDTH-1:0] Mem_Data_Write,
    output logic [3:0]        Mem_Write_Ctrl,
    output logic              Mem_Read_Ctrl,
    input  logic [DWIDTH-1:0] Mem_Data_Read,
    output logic              Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;          // requester favoured when both are valid
    logic              gnt_id_q, gnt_id_d;    // requester owning the current access
    logic [3:0]        cnt_q, cnt_d;
    logic [DWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic [DWIDTH-1:0] rdata0_q, rdata0_d;
    logic [DWIDTH-1:0] rdata1_q, rdata1_d;

    logic gnt0, gnt1;
    logic in_access;

    // A lone requester always wins; the pointer only breaks ties.
    assign gnt0 = Req0_Valid && (!Req1_Valid || !ptr_q);
    assign gnt1 = Req1_Valid && (!Req0_Valid ||  ptr_q);

    // Ready is held low while reset is asserted so no payload is accepted in that cycle.
    assign Req0_Ready = (state_q == IDLE) && gnt0 && !Rst_Core;
    assign Req1_Ready = (state_q == IDLE) && gnt1 && !Rst_Core;

    assign in_access      = (state_q == ACCESS);
    assign Mem_Data_Addr  = addr_q;
    assign Mem_Data_Write = wdata_q;
    assign Mem_Write_Ctrl = in_access ? strb_q : 4'd0;
    assign Mem_Read_Ctrl  = in_access && (strb_q == 4'd0);

    assign Req0_Done  = (state_q == RESP) && !gnt_id_q;
    assign Req1_Done  = (state_q == RESP) &&  gnt_id_q;
    assign Req0_Rdata = rdata0_q;
    assign Req1_Rdata = rdata1_q;
    assign Busy       = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    gnt_id_d = gnt1;
                    addr_d   = gnt1 ? Req1_Addr  : Req0_Addr;
                    wdata_d  = gnt1 ? Req1_Wdata : Req0_Wdata;
                    strb_d   = gnt1 ? Req1_Wstrb : Req0_Wstrb;
                    cnt_d    = 4'd0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'(MEM_LAT - 1)) begin
                    // Read data is only valid on the final cycle of the memory window.
                    if (strb_q == 4'd0) begin
                        if (gnt_id_q) rdata1_d = Mem_Data_Read;
                        else          rdata0_d = Mem_Data_Read;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                ptr_d   = !gnt_id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            gnt_id_q <= 1'b0;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= 4'd0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule
